uart_tx_escalonador: RTL and testbench
======================================

// Module: uart_tx_escalonador
// PURPOSE
// - Shares the serial UART transmitter between two byte producers: A (cube-state/status reporter) and B (debug log).
// - Fixed priority A>B writes into an internal FIFO; an FSM drains it into the transmitter via its partida/pronto handshake.
// - Sits between robot control logic and the UART transmitter, so producers never wait on serial line timing.
// PARAMETERS
// - PROF_LOG2  3       FIFO depth = 2**PROF_LOG2 bytes (8)
// - TIMEOUT    600000  max clocks in ESPERA per byte before abort (> one frame at 115200 baud, 50 MHz)
// PORTS
// - clock         in   1  system clock, 50 MHz
// - reset         in   1  synchronous, active-high
// - req_a         in   1  producer A write request, one byte per cycle
// - dado_a        in   8  producer A byte
// - aceito_a      out  1  combinational: req_a accepted on this clock edge
// - req_b         in   1  producer B write request
// - dado_b        in   8  producer B byte
// - aceito_b      out  1  combinational: req_b accepted on this clock edge
// - uart_partida  out  1  one-cycle start pulse to transmitter
// - uart_dados    out  8  byte to transmit; stable from CARREGA until ESPERA exits
// - uart_pronto   in   1  transmitter done (pulse or level)
// - ocupado       out  1  FIFO non-empty or FSM not in OCIOSO
// - erro          out  1  sticky timeout flag
// - db_estado     out  3  FSM state, debug
// BEHAVIOUR
// - Reset (sync, any state): outputs 0, FIFO emptied, FSM to OCIOSO, erro cleared; in-flight byte abandoned, no further partida.
// - Arbitration: accept a write only if FIFO not full. req_a & req_b together -> A accepted, aceito_b=0 (B holds req).
// - Full FIFO: no write accepted, even if a pop happens the same cycle (no bypass).
// - FIFO: pointers are PROF_LOG2+1 bits and wrap. Empty when equal; full when MSBs differ and the rest are equal.
// - FIFO: simultaneous push/pop on a non-empty FIFO keeps the count unchanged.
// - FSM OCIOSO: FIFO non-empty -> CARREGA.
// - FSM CARREGA: pop head into uart_dados register -> PARTIDA.
// - FSM PARTIDA: uart_partida=1 for exactly one cycle; clear timeout counter -> ESPERA.
// - FSM ESPERA: wait for a rising edge of uart_pronto (registered previous value), then -> CARREGA if FIFO non-empty, else OCIOSO.
// - uart_pronto is ignored outside ESPERA; a level already high on entry to ESPERA does not count as an edge.
// - Latency: a byte accepted at edge k with an empty FIFO and FSM in OCIOSO gives uart_partida high in the cycle after edge k+2.
// - Timeout: counter increments in ESPERA; at TIMEOUT -> erro=1, byte dropped, go to CARREGA/OCIOSO as above. erro clears only on reset.
// CONFIGURATION
// - UART_ESC_NOVALINHA_EN defined: after a byte equal to 8'h3B (';' message end) completes, FSM enters NOVALINHA.
// - NOVALINHA loads 8'h0A, then runs PARTIDA/ESPERA with the same handshake and timeout before the next FIFO byte.
// - Macro undefined: NOVALINHA state absent; bytes are sent verbatim.
// STRUCTURE
// - Package uart_esc_pkg: state encoding OCIOSO=0, CARREGA=1, PARTIDA=2, ESPERA=3, NOVALINHA=4.
// - uart_esc_pkg constants: TERMINADOR=8'h3B, NOVALINHA_ASCII=8'h0A.
// - Sub-module uart_esc_fila: synchronous FIFO (push, pop, cheia, vazia, cabeca).
// - Arbiter, FSM and timeout counter stay in this top module.
// TESTING
// - Reset 20 cycles, req_a with 0xB5 for one cycle -> partida pulse at k+3, uart_dados=0xB5 until pronto edge; ocupado=0 after.
// - req_a=0xD5 and req_b=0xFE in the same cycle -> aceito_a=1, aceito_b=0; B accepted next cycle; line order D5 then FE.
// - Hold pronto=0, A writes 10 bytes back-to-back -> 9 accepted (8 queued + 1 in uart_dados), 10th aceito_a=0; release pronto -> all 9 sent in order.
// - TIMEOUT=100, pronto never asserted -> erro=1 100 cycles after partida; next queued byte still gets a partida.
// - Assert reset during ESPERA with 3 bytes queued -> all outputs 0 next cycle, no partida afterwards, ocupado=0.
// - With UART_ESC_NOVALINHA_EN, A writes 0x3B -> two partida pulses carrying 0x3B then 0x0A.

Source files
------------

// File: rtl/uart_esc_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// the message terminator / newline byte values.
package uart_esc_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CARREGA   = 3'd1,
        PARTIDA   = 3'd2,
        ESPERA    = 3'd3,
        NOVALINHA = 3'd4
    } estado_t;

    localparam logic [7:0] TERMINADOR      = 8'h3B;
    localparam logic [7:0] NOVALINHA_ASCII = 8'h0A;

endpackage

// File: rtl/uart_esc_fila.sv
// Synchronous byte FIFO, depth 2**PROF_LOG2, with wrap-bit pointers.
// Writes while full and reads while empty are ignored; no write-through bypass.
module uart_esc_fila #(
    parameter int unsigned PROF_LOG2 = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] dado,
    input  logic       pop,
    output logic       cheia,
    output logic       vazia,
    output logic [7:0] cabeca
);
    import uart_esc_pkg::*;

    localparam int unsigned PROF = 1 << PROF_LOG2;

    logic [7:0]         mem_q [PROF];
    logic [PROF_LOG2:0] wr_q, wr_d;
    logic [PROF_LOG2:0] rd_q, rd_d;
    logic               escreve, le;

    // Full when the wrap bits differ and the index bits match.
    assign vazia   = (wr_q == rd_q);
    assign cheia   = (wr_q[PROF_LOG2] != rd_q[PROF_LOG2]) &&
                     (wr_q[PROF_LOG2-1:0] == rd_q[PROF_LOG2-1:0]);
    assign escreve = push && !cheia;
    assign le      = pop && !vazia;
    assign cabeca  = mem_q[rd_q[PROF_LOG2-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (escreve) wr_d = wr_q + 1'b1;
        if (le)      rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (escreve) mem_q[wr_q[PROF_LOG2-1:0]] <= dado;
    end

endmodule

// File: rtl/uart_tx_escalonador.sv
// Shares one UART transmitter between producers A (priority) and B via a FIFO.
// Optional UART_ESC_NOVALINHA_EN appends 8'h0A after every 8'h3B sent.
module uart_tx_escalonador #(
    parameter int unsigned PROF_LOG2 = 3,
    parameter int unsigned TIMEOUT   = 600000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic [7:0] dado_a,
    output logic       aceito_a,
    input  logic       req_b,
    input  logic [7:0] dado_b,
    output logic       aceito_b,
    output logic       uart_partida,
    output logic [7:0] uart_dados,
    input  logic       uart_pronto,
    output logic       ocupado,
    output logic       erro,
    output logic [2:0] db_estado
);
    import uart_esc_pkg::*;

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    estado_t       estado_q, estado_d;
    logic [7:0]    dados_q, dados_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          erro_q, erro_d;
    logic          pronto_ant_q;

    logic          cheia, vazia, push, pop, fim_espera, borda;
    logic [7:0]    cabeca, dado_push;

    assign aceito_a  = req_a && !cheia && !reset;
    assign aceito_b  = req_b && !req_a && !cheia && !reset;
    assign push      = aceito_a || aceito_b;
    assign dado_push = aceito_a ? dado_a : dado_b;

    uart_esc_fila #(
        .PROF_LOG2(PROF_LOG2)
    ) u_fila (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .dado  (dado_push),
        .pop   (pop),
        .cheia (cheia),
        .vazia (vazia),
        .cabeca(cabeca)
    );

    assign borda = uart_pronto && !pronto_ant_q;

    always_comb begin
        estado_d     = estado_q;
        dados_d      = dados_q;
        cnt_d        = cnt_q;
        erro_d       = erro_q;
        pop          = 1'b0;
        uart_partida = 1'b0;
        fim_espera   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (!vazia) estado_d = CARREGA;
            end
            CARREGA: begin
                pop      = 1'b1;
                dados_d  = cabeca;
                estado_d = PARTIDA;
            end
            PARTIDA: begin
                uart_partida = 1'b1;
                // Counter counts clocks since the partida cycle, hence starts at 1.
                cnt_d        = CW'(1);
                estado_d     = ESPERA;
            end
            ESPERA: begin
                cnt_d = cnt_q + CW'(1);
                if (borda) begin
                    fim_espera = 1'b1;
                end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                    fim_espera = 1'b1;
                    erro_d     = 1'b1;
                end
                if (fim_espera) begin
                    estado_d = vazia ? OCIOSO : CARREGA;
`ifdef UART_ESC_NOVALINHA_EN
                    if (dados_q == TERMINADOR) estado_d = NOVALINHA;
`endif
                end
            end
`ifdef UART_ESC_NOVALINHA_EN
            NOVALINHA: begin
                dados_d  = NOVALINHA_ASCII;
                estado_d = PARTIDA;
            end
`endif
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            dados_q      <= '0;
            cnt_q        <= '0;
            erro_q       <= 1'b0;
            pronto_ant_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            dados_q      <= dados_d;
            cnt_q        <= cnt_d;
            erro_q       <= erro_d;
            pronto_ant_q <= uart_pronto;
        end
    end

    assign uart_dados = dados_q;
    assign erro       = erro_q;
    assign db_estado  = estado_q;
    assign ocupado    = !vazia || (estado_q != OCIOSO);

endmodule

// File: tb/tb_uart_tx_escalonador.sv
// Directed self-checking bench for uart_tx_escalonador (TIMEOUT=100).
// Define UART_ESC_NOVALINHA_EN to also exercise the newline insertion.
module tb_uart_tx_escalonador;

    logic       clock;
    logic       reset;
    logic       req_a, req_b;
    logic [7:0] dado_a, dado_b;
    logic       aceito_a, aceito_b;
    logic       uart_partida;
    logic [7:0] uart_dados;
    logic       uart_pronto;
    logic       ocupado, erro;
    logic [2:0] db_estado;

    logic       auto_pronto = 1'b0;
    logic [7:0] sent[$];
    int         n_partida = 0;
    int         total = 0;
    int         bad = 0;

    uart_tx_escalonador #(
        .PROF_LOG2(3),
        .TIMEOUT  (100)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_a       (req_a),
        .dado_a      (dado_a),
        .aceito_a    (aceito_a),
        .req_b       (req_b),
        .dado_b      (dado_b),
        .aceito_b    (aceito_b),
        .uart_partida(uart_partida),
        .uart_dados  (uart_dados),
        .uart_pronto (uart_pronto),
        .ocupado     (ocupado),
        .erro        (erro),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Line monitor: logs every byte that gets a start pulse.
    always @(negedge clock) begin
        if (uart_partida === 1'b1) begin
            sent.push_back(uart_dados);
            n_partida++;
        end
    end

    // Transmitter model: when enabled, pulses pronto one cycle after seeing ESPERA.
    initial begin
        uart_pronto = 1'b0;
        forever begin
            @(negedge clock);
            if (auto_pronto && db_estado == 3'd3) begin
                @(posedge clock); #1 uart_pronto = 1'b1;
                @(posedge clock); #1 uart_pronto = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic aplica_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; dado_a = '0; dado_b = '0;
        auto_pronto = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("rst_partida", uart_partida, 0);
        chk("rst_dados", uart_dados, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_erro", erro, 0);
        chk("rst_estado", db_estado, 0);
        @(posedge clock); #1 reset = 1'b0;
    endtask

    task automatic espera_enviados(input int n, input int limite, input string nome);
        int c = 0;
        while (sent.size() < n && c < limite) begin
            @(negedge clock); #1; c++;
        end
        chk(nome, sent.size(), n);
    endtask

    task automatic espera_livre(input int limite, input string nome);
        int c = 0;
        while (ocupado !== 1'b0 && c < limite) begin
            @(negedge clock); c++;
        end
        chk(nome, ocupado, 0);
    endtask

    typedef struct {
        logic       ra;
        logic [7:0] da;
        logic       rb;
        logic [7:0] db;
        logic       ea;
        logic       eb;
    } vec_t;

    vec_t vetor[5];

    initial begin
        int base;
        int np;
        int c;

        vetor[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vetor[1] = '{1'b1, 8'hD5, 1'b1, 8'hFE, 1'b1, 1'b0};
        vetor[2] = '{1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b1};
        vetor[3] = '{1'b0, 8'h00, 1'b1, 8'h27, 1'b0, 1'b1};
        vetor[4] = '{1'b1, 8'h61, 1'b0, 8'h00, 1'b1, 1'b0};

        // Single byte latency and hold of uart_dados.
        aplica_reset();
        base = sent.size();
        req_a = 1'b1; dado_a = 8'hB5;
        @(negedge clock);
        chk("lat_aceito", aceito_a, 1);
        @(posedge clock); #1 req_a = 1'b0;
        @(negedge clock);
        chk("lat_k_partida", uart_partida, 0);
        chk("lat_k_ocupado", ocupado, 1);
        @(negedge clock);
        chk("lat_k1_partida", uart_partida, 0);
        chk("lat_k1_estado", db_estado, 3'd1);
        @(negedge clock);
        chk("lat_k2_partida", uart_partida, 1);
        chk("lat_k2_dados", uart_dados, 8'hB5);
        @(negedge clock);
        chk("lat_k3_partida", uart_partida, 0);
        chk("lat_k3_estado", db_estado, 3'd3);
        repeat (5) @(negedge clock);
        chk("lat_hold_dados", uart_dados, 8'hB5);
        auto_pronto = 1'b1;
        espera_livre(30, "lat_ocupado_fim");
        #1;
        chk("lat_count", sent.size(), base + 1);
        chk("lat_byte", sent[base], 8'hB5);

        // Arbitration table.
        aplica_reset();
        auto_pronto = 1'b1;
        base = sent.size();
        for (int i = 0; i < 5; i++) begin
            req_a = vetor[i].ra; dado_a = vetor[i].da;
            req_b = vetor[i].rb; dado_b = vetor[i].db;
            @(negedge clock);
            chk($sformatf("arb%0d_aceito_a", i), aceito_a, vetor[i].ea);
            chk($sformatf("arb%0d_aceito_b", i), aceito_b, vetor[i].eb);
            @(posedge clock); #1;
        end
        req_a = 1'b0; req_b = 1'b0;
        espera_enviados(base + 4, 200, "arb_count");
        chk("arb_ord0", sent[base],     8'hD5);
        chk("arb_ord1", sent[base + 1], 8'hFE);
        chk("arb_ord2", sent[base + 2], 8'h27);
        chk("arb_ord3", sent[base + 3], 8'h61);

        // Full FIFO: 8 queued + 1 held in uart_dados, the 10th is refused.
        aplica_reset();
        base = sent.size();
        for (int i = 0; i < 10; i++) begin
            req_a = 1'b1; dado_a = 8'h10 + 8'(i);
            @(negedge clock);
            chk($sformatf("cheia_aceito%0d", i), aceito_a, (i < 9) ? 1 : 0);
            @(posedge clock); #1;
        end
        req_a = 1'b0;
        auto_pronto = 1'b1;
        espera_enviados(base + 9, 300, "cheia_count");
        for (int i = 0; i < 9; i++)
            chk($sformatf("cheia_ord%0d", i), sent[base + i], 8'h10 + 8'(i));
        espera_livre(30, "cheia_ocupado_fim");
        repeat (5) @(negedge clock);
        #1;
        chk("cheia_sem_extra", sent.size(), base + 9);
        chk("cheia_erro", erro, 0);

        // Timeout with pronto never asserted.
        aplica_reset();
        req_a = 1'b1; dado_a = 8'hA1;
        @(posedge clock); #1 dado_a = 8'hA2;
        @(posedge clock); #1 req_a = 1'b0;
        c = 0;
        while (uart_partida !== 1'b1 && c < 10) begin
            @(negedge clock); c++;
        end
        chk("to_partida1", uart_partida, 1);
        chk("to_dados1", uart_dados, 8'hA1);
        repeat (99) @(negedge clock);
        chk("to_erro_c99", erro, 0);
        @(negedge clock);
        chk("to_erro_c100", erro, 1);
        c = 0;
        while (uart_partida !== 1'b1 && c < 10) begin
            @(negedge clock); c++;
        end
        chk("to_partida2", uart_partida, 1);
        chk("to_dados2", uart_dados, 8'hA2);
        auto_pronto = 1'b1;
        espera_livre(30, "to_ocupado_fim");
        chk("to_erro_sticky", erro, 1);

        // Reset while waiting with three bytes queued.
        aplica_reset();
        for (int i = 0; i < 4; i++) begin
            req_a = 1'b1; dado_a = 8'hC0 + 8'(i);
            @(posedge clock); #1;
        end
        req_a = 1'b0;
        c = 0;
        while (db_estado !== 3'd3 && c < 10) begin
            @(negedge clock); c++;
        end
        chk("rst2_em_espera", db_estado, 3'd3);
        @(posedge clock); #1 reset = 1'b1; req_a = 1'b1; dado_a = 8'h77;
        @(posedge clock);
        @(negedge clock);
        chk("rst2_partida", uart_partida, 0);
        chk("rst2_dados", uart_dados, 0);
        chk("rst2_ocupado", ocupado, 0);
        chk("rst2_erro", erro, 0);
        chk("rst2_estado", db_estado, 0);
        chk("rst2_aceito_a", aceito_a, 0);
        @(posedge clock); #1 reset = 1'b0; req_a = 1'b0;
        np = n_partida;
        repeat (30) @(negedge clock);
        #1;
        chk("rst2_sem_partida", n_partida - np, 0);
        chk("rst2_ocupado_fim", ocupado, 0);

`ifdef UART_ESC_NOVALINHA_EN
        // Terminator is followed by a newline byte.
        aplica_reset();
        auto_pronto = 1'b1;
        base = sent.size();
        req_a = 1'b1; dado_a = 8'h3B;
        @(posedge clock); #1 req_a = 1'b0;
        espera_enviados(base + 2, 100, "nl_count");
        chk("nl_byte0", sent[base],     8'h3B);
        chk("nl_byte1", sent[base + 1], 8'h0A);
        espera_livre(30, "nl_ocupado_fim");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
